// File: rtl/edge_frame_sink.sv
// edge_frame_sink: captures one Sobel edge-image frame into an internal
// buffer, then streams it back out in raster order with valid/ready.
// Optional build macro EDGE_SINK_THRESH_EN: binarize pixels against THRESH
// before they are stored (255 at or above THRESH, else 0).
module edge_frame_sink #(
  parameter int WIDTH  = 510,
  parameter int HEIGHT = 510,
  parameter int THRESH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(WIDTH);
  localparam int unsigned RW    = $clog2(HEIGHT);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      wr_pixel;
  logic [7:0]      mem [DEPTH];

  logic cap_beat, cap_last, start_ok;
  logic rd_fire, rd_done, rd_load;

  assign start_ok = (state == IDLE) && start;
  assign cap_beat = (state == CAPTURE) && valid_in;
  assign cap_last = cap_beat && (col == LAST_COL) && (row == LAST_ROW);
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_done  = rd_fire && rd_last;
  // The output register doubles as the buffer's read register: refill it
  // whenever it is empty or being consumed, until the last pixel is in it.
  assign rd_load  = (state == READOUT) && (!rd_valid || rd_ready) &&
                    !(rd_valid && rd_last);

`ifdef EDGE_SINK_THRESH_EN
  // Binarize incoming edge magnitude before storage
  always_comb begin
    wr_pixel = (pixel_in >= 8'(THRESH)) ? 8'd255 : 8'd0;
  end
`else
  // Store edge magnitude unmodified
  always_comb begin
    wr_pixel = pixel_in;
  end

  // Threshold has no role in this build.
  logic [7:0] unused_thresh;
  assign unused_thresh = 8'(THRESH);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = CAPTURE;
      CAPTURE: if (cap_last) state_nxt = READOUT;
      READOUT: if (rd_done)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Capture position: column/row raster counters plus linear write address
  always_ff @(posedge clk) begin
    if (rst || cap_last) begin
      col     <= '0;
      row     <= '0;
      wr_addr <= '0;
    end else if (cap_beat) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      wr_addr <= wr_addr + AW'(1);
    end
  end

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (!rst && cap_beat) mem[wr_addr] <= wr_pixel;
  end

  // Readout: registered buffer read feeding the valid/ready output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= rd_done;
      if (rd_load) begin
        rd_data  <= mem[rd_addr];
        rd_valid <= 1'b1;
        rd_last  <= (rd_addr == LAST_ADDR);
        rd_addr  <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  // Sticky overflow: any beat outside CAPTURE; cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst)                                 overflow <= 1'b0;
    else if (valid_in && state != CAPTURE)   overflow <= 1'b1;
    else if (start_ok)                       overflow <= 1'b0;
  end

endmodule

// File: tb/tb_edge_frame_sink.sv
// Directed bench for edge_frame_sink with a 4x3 frame.
module tb_edge_frame_sink;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int NV = 27;

  logic       clk = 1'b0;
  logic       rst, start, valid_in, rd_ready;
  logic [7:0] pixel_in;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, busy, done, overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_pix  [N];
  logic [7:0] exp_pix [N];

  typedef struct {
    logic       s_start;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pix;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t vt [NV];

  always #5 clk = ~clk;

  edge_frame_sink #(.WIDTH(W), .HEIGHT(H), .THRESH(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pixel_in (pixel_in),
    .valid_in (valid_in),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  function automatic logic [7:0] model(input logic [7:0] p);
`ifdef EDGE_SINK_THRESH_EN
    return (p >= 8'd128) ? 8'd255 : 8'd0;
`else
    return p;
`endif
  endfunction

  function automatic vec_t mk(input logic s, input logic v, input logic r,
                              input logic [7:0] p, input logic ev,
                              input logic [7:0] ed, input logic el,
                              input logic edn, input logic eb);
    vec_t x;
    x.s_start = s;  x.s_valid = v;  x.s_ready = r;  x.s_pix = p;
    x.e_valid = ev; x.e_data = ed;  x.e_last = el;  x.e_done = edn;
    x.e_busy = eb;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input bit gaps);
    for (int i = 0; i < N; i++) begin
      valid_in = 1'b1;
      pixel_in = in_pix[i];
      tick();
      if (gaps) begin
        valid_in = 1'b0;
        pixel_in = 8'h5A;
        tick();
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic set_expect();
    for (int i = 0; i < N; i++) exp_pix[i] = model(in_pix[i]);
  endtask

  // Drains one frame, optionally stalling at one index and pulsing start
  // at another; checks order, rd_last, stall hold and a single done pulse.
  task automatic run_readout(input string tag, input int stall_at,
                             input int stall_len, input int start_at);
    int idx = 0;
    int stalls = 0;
    bit fin = 1'b0;
    bit pulsed = 1'b0;
    for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
      start    = 1'b0;
      rd_ready = 1'b1;
      if (done) begin
        fin = 1'b1;
      end else begin
        if (rd_valid && idx == stall_at && stalls < stall_len) begin
          rd_ready = 1'b0;
          stalls++;
        end
        if (rd_valid && idx == start_at && !pulsed) begin
          start  = 1'b1;
          pulsed = 1'b1;
        end
        if (rd_valid) begin
          if (idx >= N) begin
            check({tag, " extra_beat"}, 1, 0);
            fin = 1'b1;
          end else begin
            check($sformatf("%s data[%0d]", tag, idx), rd_data, exp_pix[idx]);
            check($sformatf("%s last[%0d]", tag, idx), rd_last, (idx == N-1));
            if (rd_ready) idx++;
          end
        end
        if (!fin) tick();
      end
    end
    start    = 1'b0;
    rd_ready = 1'b1;
    check({tag, " done_seen"}, done, 1);
    check({tag, " beats"}, idx, N);
    check({tag, " stall_cycles"}, stalls, (stall_at >= 0) ? stall_len : 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("%s done_after%0d", tag, k), done, 0);
      check($sformatf("%s busy_after%0d", tag, k), busy, 0);
      check($sformatf("%s valid_after%0d", tag, k), rd_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; valid_in = 1'b1; pixel_in = 8'h33; rd_ready = 1'b1;

    // Reset wins over start/valid_in/rd_ready in the same cycle
    tick();
    tick();
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_last", rd_last, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst overflow", overflow, 0);
    rst = 1'b0; start = 1'b0; valid_in = 1'b0; pixel_in = 8'h00;
    tick();
    check("idle busy", busy, 0);

    // Table: start, 12 back-to-back beats 0..11, readout with rd_ready high
    vt[0] = mk(1, 0, 1, 8'd0, 0, 8'd0, 0, 0, 1);
    for (int i = 0; i < N; i++)
      vt[1+i] = mk(0, 1, 1, 8'(i), 0, 8'd0, 0, 0, 1);
    for (int k = 0; k < N; k++)
      vt[13+k] = mk(0, 0, 1, 8'd0, 1, model(8'(k)), (k == N-1), 0, 1);
    vt[25] = mk(0, 0, 1, 8'd0, 0, 8'd0, 0, 1, 0);
    vt[26] = mk(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      start    = vt[i].s_start;
      valid_in = vt[i].s_valid;
      rd_ready = vt[i].s_ready;
      pixel_in = vt[i].s_pix;
      tick();
      check($sformatf("vec%0d rd_valid", i), rd_valid, vt[i].e_valid);
      if (vt[i].e_valid)
        check($sformatf("vec%0d rd_data", i), rd_data, vt[i].e_data);
      check($sformatf("vec%0d rd_last", i), rd_last, vt[i].e_last);
      check($sformatf("vec%0d done", i), done, vt[i].e_done);
      check($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d overflow", i), overflow, 0);
    end
    start = 1'b0; valid_in = 1'b0;

    // Gapped capture, 3-cycle stall at index 5
    for (int i = 0; i < N; i++) in_pix[i] = 8'(40 + i);
    set_expect();
    start = 1'b1; tick(); start = 1'b0;
    capture(1'b1);
    check("gap overflow", overflow, 0);
    run_readout("gap", 5, 3, -1);

    // Overflow in IDLE, cleared by the next accepted start
    valid_in = 1'b1; pixel_in = 8'hAA;
    tick();
    valid_in = 1'b0;
    check("ovf set", overflow, 1);
    check("ovf idle busy", busy, 0);
    tick();
    check("ovf sticky", overflow, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("ovf cleared", overflow, 0);
    check("ovf start busy", busy, 1);

    // Threshold pattern, start pulsed during READOUT must be ignored
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: in_pix[i] = 8'd127;
        1: in_pix[i] = 8'd128;
        2: in_pix[i] = 8'd0;
        default: in_pix[i] = 8'd255;
      endcase
    end
    set_expect();
    capture(1'b0);
    run_readout("thr", -1, 0, 4);

    // Abort mid-capture with reset, then a fresh frame from address 0
    for (int i = 0; i < N; i++) in_pix[i] = 8'(200 + i);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      valid_in = 1'b1; pixel_in = in_pix[i];
      tick();
    end
    valid_in = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort rd_valid", rd_valid, 0);
    for (int i = 0; i < N; i++) in_pix[i] = 8'(100 + i);
    set_expect();
    start = 1'b1; tick(); start = 1'b0;
    capture(1'b0);
    run_readout("abort", -1, 0, -1);

    // Beat during READOUT sets overflow
    for (int i = 0; i < N; i++) in_pix[i] = 8'(i * 7);
    start = 1'b1; tick(); start = 1'b0;
    capture(1'b0);
    check("rdovf busy", busy, 1);
    check("rdovf before", overflow, 0);
    valid_in = 1'b1; rd_ready = 1'b0;
    tick();
    valid_in = 1'b0;
    check("rdovf set", overflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_frame_sink.md
EDGE_FRAME_SINK -- requirements
Module: edge_frame_sink

Interface
REQ-001 Parameter WIDTH, default 510: pixels per edge-image row (Sobel output row width); minimum 2.
REQ-002 Parameter HEIGHT, default 510: rows per edge-image frame; minimum 2.
REQ-003 Parameter THRESH, default 128: 8-bit binarization threshold, used only under EDGE_SINK_THRESH_EN.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  single-cycle request to arm capture of one frame.
REQ-007 pixel_in  input  8  edge magnitude from the Sobel stream.
REQ-008 valid_in  input  1  pixel_in qualifier; one beat per cycle high, no backpressure.
REQ-009 rd_ready  input  1  downstream readout ready.
REQ-010 rd_data  output  8  readout pixel, raster order.
REQ-011 rd_valid  output  1  rd_data qualifier.
REQ-012 rd_last  output  1  high with the final readout beat of the frame.
REQ-013 busy  output  1  high in CAPTURE or READOUT.
REQ-014 done  output  1  one-cycle pulse on the cycle after the final readout handshake.
REQ-015 overflow  output  1  sticky: valid_in seen while not capturing.

Function
REQ-016 States SHALL be IDLE, CAPTURE, READOUT.
REQ-017 IDLE -> CAPTURE on start; start in CAPTURE or READOUT SHALL be ignored.
REQ-018 In CAPTURE, each valid_in beat SHALL write pixel_in to frame buffer address row*WIDTH+col; col increments, wraps WIDTH-1 -> 0 and increments row.
REQ-019 The beat at col==WIDTH-1, row==HEIGHT-1 SHALL be written and SHALL move the state to READOUT on the next cycle; col/row reset to 0.
REQ-020 Cycles with valid_in low SHALL not advance counters; gaps of any length SHALL be tolerated.
REQ-021 valid_in high in IDLE or READOUT SHALL set overflow and discard the pixel; no buffer write.
REQ-022 Frame buffer SHALL be WIDTH*HEIGHT x 8-bit, single write port, synchronous read with 1-cycle latency.
REQ-023 rd_valid SHALL first assert exactly 2 cycles after the final capture beat, carrying address 0.
REQ-024 A handshake is rd_valid && rd_ready; each handshake advances the read address by one, raster order.
REQ-025 While rd_valid && !rd_ready, rd_data and rd_last SHALL hold stable.
REQ-026 With rd_ready held high, one pixel SHALL be delivered per cycle with no bubbles.
REQ-027 rd_last SHALL be high only with address WIDTH*HEIGHT-1.
REQ-028 On the rd_last handshake: rd_valid deasserts next cycle, done pulses next cycle, state returns to IDLE next cycle.
REQ-029 busy SHALL be combinationally equal to (state != IDLE).
REQ-030 Buffer contents SHALL persist until overwritten by a later capture.

Reset
REQ-031 rst SHALL force state IDLE, counters 0, rd_data 0, rd_valid 0, rd_last 0, done 0, overflow 0; busy 0.
REQ-032 rst SHALL take priority over start, valid_in and rd_ready in the same cycle.
REQ-033 rst mid-CAPTURE or mid-READOUT SHALL abort the frame; a fresh start SHALL restart at address 0.
REQ-034 overflow SHALL clear only on rst or on an accepted start.

Configuration
REQ-035 Macro EDGE_SINK_THRESH_EN defined: stored pixel = 8'd255 if pixel_in >= THRESH, else 8'd0.
REQ-036 EDGE_SINK_THRESH_EN undefined: pixel_in stored unmodified; THRESH unused.

Verification (WIDTH=4, HEIGHT=3 unless stated)
REQ-037 rst, start, 12 beats pixel_in=0..11 back-to-back, rd_ready=1 -> rd_valid 2 cycles after beat 11, rd_data 0..11 consecutive, rd_last on 11, done one cycle later, busy low after.
REQ-038 Capture with valid_in toggling 1/0 and rd_ready low for 3 cycles at pixel 5 -> all 12 stored; rd_data=5 held for 3 cycles; no loss or duplicate.
REQ-039 valid_in=1 with pixel_in=0xAA while IDLE -> overflow=1, no write; next start -> overflow=0.
REQ-040 rst asserted after 7 capture beats, then start and 12 beats 100..111 -> readout 100..111 only.
REQ-041 start pulsed during READOUT -> ignored; readout completes, single done.
REQ-042 EDGE_SINK_THRESH_EN, THRESH=128, inputs 127,128,0,255 repeated -> readout 0,255,0,255 repeated.
